// File: rtl/sipo_deframer.sv
// LSB-first serial-to-parallel deframer: start-marked words are shifted into sr,
// then handed to a one-entry valid/ready output register with overrun/frame_err pulses.
module sipo_deframer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;
  logic             frame_err_q, frame_err_d;
  logic [WIDTH-1:0] shift_s;
  logic             done_s;

  // Next-state: framing FSM, bit counter and output-register accept/drain.
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    cnt_d        = cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = 1'b0;
    frame_err_d  = 1'b0;
    done_s       = 1'b0;
    shift_s      = WIDTH'({sin, sr_q} >> 1);

    if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end else begin
      dout_valid_d = dout_valid_q;
    end

    case (state_q)
      IDLE: begin
        if (sin_valid && sin_start) begin
          sr_d    = shift_s;
          cnt_d   = CW'(1);
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (sin_valid) begin
          sr_d = shift_s;
          if (sin_start) begin
            // Stale bits are shifted out by the time the restarted word completes.
            frame_err_d = 1'b1;
            cnt_d       = CW'(1);
          end else if (cnt_q == CNT_LAST) begin
            done_s  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (done_s) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = shift_s;
        dout_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else begin
      overrun_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q == SHIFT);
  assign overrun    = overrun_q;
  assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_sipo_deframer.sv
// Self-checking bench for sipo_deframer: queue-based word model checked every cycle,
// directed scenarios pinned with literal expectations, then randomized traffic.
module tb_sipo_deframer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rstn, sin, sin_valid, sin_start, dout_ready;
  logic [W-1:0] dout;
  logic         dout_valid, busy, overrun, frame_err;

  int n_chk  = 0;
  int n_fail = 0;
  int busy_cycles;

  // Model: bits of the word in progress, plus the expected output register.
  bit           q[$];
  logic [W-1:0] m_dout;
  logic         m_valid, m_ov, m_fe;

  always #5 clk = ~clk;

  sipo_deframer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .sin        (sin),
    .sin_valid  (sin_valid),
    .sin_start  (sin_start),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .overrun    (overrun),
    .frame_err  (frame_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input logic v, input logic s, input logic b, input logic r, input logic rs);
    logic [W-1:0] word;
    logic         done;
    rstn = rs; sin_valid = v; sin_start = s; sin = b; dout_ready = r;
    done = 1'b0;
    word = '0;
    if (!rs) begin
      q.delete();
      m_dout = '0; m_valid = 1'b0; m_ov = 1'b0; m_fe = 1'b0;
    end else begin
      m_ov = 1'b0;
      m_fe = 1'b0;
      if (v) begin
        if (s) begin
          if (q.size() != 0) m_fe = 1'b1;
          q.delete();
          q.push_back(b);
        end else if (q.size() != 0) begin
          q.push_back(b);
          if (q.size() == W) begin
            for (int i = 0; i < W; i++) word[i] = q[i];
            done = 1'b1;
            q.delete();
          end
        end
      end
      if (done) begin
        if (!m_valid || r) begin
          m_dout  = word;
          m_valid = 1'b1;
        end else begin
          m_ov = 1'b1;
        end
      end else if (m_valid && r) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("dout",       32'(dout),       32'(m_dout));
    chk("dout_valid", 32'(dout_valid), 32'(m_valid));
    chk("busy",       32'(busy),       32'(q.size() != 0));
    chk("overrun",    32'(overrun),    32'(m_ov));
    chk("frame_err",  32'(frame_err),  32'(m_fe));
    if (busy) busy_cycles++;
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic r_rest, input logic r_last);
    for (int i = 0; i < W; i++)
      step(1'b1, i == 0, w[i], (i == W - 1) ? r_last : r_rest, 1'b1);
  endtask

  initial begin
    // Reset state
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_valid", 32'(dout_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    // Back-to-back 1,0,0,1 with ready high
    busy_cycles = 0;
    send_word(4'b1001, 1'b1, 1'b1);
    chk("t1_dout", 32'(dout), 32'h9);
    chk("t1_valid", 32'(dout_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t1_valid_drop", 32'(dout_valid), 32'h0);
    chk("t1_busy_cycles", 32'(busy_cycles), 32'd3);

    // 0,1,gap,gap,1,0
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t2_not_yet", 32'(dout_valid), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t2_dout", 32'(dout), 32'h6);
    chk("t2_valid", 32'(dout_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Overrun with ready held low
    send_word(4'b1001, 1'b0, 1'b0);
    send_word(4'b0011, 1'b0, 1'b0);
    chk("t3_overrun", 32'(overrun), 32'h1);
    chk("t3_dout", 32'(dout), 32'h9);
    chk("t3_valid", 32'(dout_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_overrun_pulse", 32'(overrun), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t3_drained", 32'(dout_valid), 32'h0);

    // Ready arrives exactly on the completing edge of the next word
    send_word(4'b1001, 1'b0, 1'b0);
    send_word(4'b0011, 1'b0, 1'b1);
    chk("t4_dout", 32'(dout), 32'h3);
    chk("t4_valid", 32'(dout_valid), 32'h1);
    chk("t4_no_overrun", 32'(overrun), 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Restart mid-word
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t5_frame_err", 32'(frame_err), 32'h1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5_fe_pulse", 32'(frame_err), 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5_dout", 32'(dout), 32'hA);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset mid-word
    send_word(4'b0101, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_rst_dout", 32'(dout), 32'h0);
    chk("t6_rst_valid", 32'(dout_valid), 32'h0);
    chk("t6_rst_busy", 32'(busy), 32'h0);
    send_word(4'b1111, 1'b1, 1'b1);
    chk("t6_dout", 32'(dout), 32'hF);
    chk("t6_no_fe", 32'(frame_err), 32'h0);

    // Randomized traffic
    for (int n = 0; n < 4000; n++)
      step($urandom_range(3, 0) != 0, $urandom_range(5, 0) == 0, 1'($urandom),
           $urandom_range(2, 0) != 0, $urandom_range(199, 0) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
